// File: rtl/vga_text_console.sv
// VGA text-mode console: sync timing, COLS x ROWS character buffer with cursor,
// and a 3-stage render pipeline through an external synchronous font ROM.
module vga_text_console #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int COLS         = H_ACTIVE / CHAR_W,
  parameter int ROWS         = V_ACTIVE / CHAR_H,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_valid,
  input  logic [7:0]                  i_wr_char,
  output logic                        o_wr_ready,
  input  logic                        i_clr,
  output logic [7:0]                  o_font_code,
  output logic [$clog2(CHAR_H)-1:0]   o_font_row,
  input  logic [CHAR_W-1:0]           i_font_bits,
  output logic                        o_vga_h_sync,
  output logic                        o_vga_v_sync,
  output logic                        o_in_display_area,
  output logic                        o_pixel_on,
  output logic [$clog2(COLS)-1:0]     o_cur_col,
  output logic [$clog2(ROWS)-1:0]     o_cur_row
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CELLS   = COLS * ROWS;
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  localparam int AW = $clog2(CELLS);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int GW = $clog2(CHAR_H);
  localparam int BW = $clog2(CHAR_W);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;
  logic [FW-1:0] r_frame;
  logic          r_blink;
  logic [7:0]    r_mem [CELLS];
  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_clr_addr, w_clr_addr_nxt;
  logic [CW-1:0] r_cur_col, w_col_nxt;
  logic [RW-1:0] r_cur_row, w_row_nxt, w_row_inc;
  logic          r_wr_ready;
  logic          w_we;
  logic [AW-1:0] w_waddr, w_cur_addr, w_rd_addr;
  logic [7:0]    w_wdata;

  logic          w_act, w_hs, w_vs, w_hit, w_last_x, w_last_y;
  logic [CW-1:0] w_cell_col;
  logic [RW-1:0] w_cell_row;
  logic [GW-1:0] w_glyph_row;
  logic [BW-1:0] w_glyph_bit;

  logic [7:0]    r_rd_char;
  logic [GW-1:0] r_font_row;
  logic [BW-1:0] r_bit1, r_bit2;
  logic          r_hit1, r_hit2, r_act1, r_act2, r_hs1, r_hs2, r_vs1, r_vs2;
  logic          r_pixel, r_disp, r_hs, r_vs;

  assign w_last_x    = (r_cx == XW'(H_TOTAL - 1));
  assign w_last_y    = (r_cy == YW'(V_TOTAL - 1));
  assign w_act       = (r_cx < XW'(H_ACTIVE)) && (r_cy < YW'(V_ACTIVE));
  assign w_hs        = !((r_cx >= XW'(H_ACTIVE + H_FP)) && (r_cx <= XW'(H_ACTIVE + H_FP + H_SYNC - 1)));
  assign w_vs        = !((r_cy >= YW'(V_ACTIVE + V_FP)) && (r_cy <= YW'(V_ACTIVE + V_FP + V_SYNC - 1)));
  assign w_cell_col  = CW'(r_cx / XW'(CHAR_W));
  assign w_cell_row  = RW'(r_cy / YW'(CHAR_H));
  assign w_glyph_row = GW'(r_cy % YW'(CHAR_H));
  assign w_glyph_bit = BW'(r_cx % XW'(CHAR_W));
  // Outside the visible area the cell indices alias, so the read address is parked.
  assign w_rd_addr   = w_act ? (AW'(w_cell_row) * AW'(COLS) + AW'(w_cell_col)) : '0;
  assign w_hit       = w_act && r_blink && (w_cell_col == r_cur_col) && (w_cell_row == r_cur_row)
                       && (w_glyph_row >= GW'(CHAR_H - 2));
  assign w_cur_addr  = AW'(r_cur_row) * AW'(COLS) + AW'(r_cur_col);
  assign w_row_inc   = (r_cur_row == RW'(ROWS - 1)) ? '0 : r_cur_row + RW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_last_x) begin
      r_cx <= '0;
      r_cy <= w_last_y ? '0 : r_cy + YW'(1);
    end else begin
      r_cx <= r_cx + XW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame <= '0;
      r_blink <= 1'b0;
    end else if (w_last_x && w_last_y) begin
      if (r_frame == FW'(BLINK_FRAMES - 1)) begin
        r_frame <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_frame <= r_frame + FW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_cur_col  <= '0;
      r_cur_row  <= '0;
      r_wr_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_cur_col  <= w_col_nxt;
      r_cur_row  <= w_row_nxt;
      r_wr_ready <= (w_state_nxt == S_RUN);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_col_nxt      = r_cur_col;
    w_row_nxt      = r_cur_row;
    w_we           = 1'b0;
    w_waddr        = r_clr_addr;
    w_wdata        = 8'h20;
    case (r_state)
      S_CLEAR: begin
        w_we = 1'b1;
        if (i_clr) begin
          w_clr_addr_nxt = '0;
        end else if (r_clr_addr == AW'(CELLS - 1)) begin
          w_state_nxt    = S_RUN;
          w_clr_addr_nxt = '0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + AW'(1);
        end
      end
      S_RUN: begin
        // clr takes priority; a byte offered in the same cycle is dropped.
        if (i_clr) begin
          w_state_nxt    = S_CLEAR;
          w_clr_addr_nxt = '0;
          w_col_nxt      = '0;
          w_row_nxt      = '0;
        end else if (i_wr_valid) begin
          if ((i_wr_char >= 8'h20) && (i_wr_char <= 8'h7E)) begin
            w_we    = 1'b1;
            w_waddr = w_cur_addr;
            w_wdata = i_wr_char;
            if (r_cur_col == CW'(COLS - 1)) begin
              w_col_nxt = '0;
              w_row_nxt = w_row_inc;
            end else begin
              w_col_nxt = r_cur_col + CW'(1);
            end
          end else if (i_wr_char == 8'h0A) begin
            w_col_nxt = '0;
            w_row_nxt = w_row_inc;
          end else if (i_wr_char == 8'h08) begin
            if (r_cur_col != '0) begin
              w_col_nxt = r_cur_col - CW'(1);
            end else if (r_cur_row != '0) begin
              w_col_nxt = CW'(COLS - 1);
              w_row_nxt = r_cur_row - RW'(1);
            end else begin
              w_col_nxt = r_cur_col;
            end
          end else begin
            w_col_nxt = r_cur_col;
          end
        end else begin
          w_col_nxt = r_cur_col;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_char  <= 8'h20;
      r_font_row <= '0;
      r_bit1     <= '0;
      r_hit1     <= 1'b0;
      r_act1     <= 1'b0;
      r_hs1      <= 1'b1;
      r_vs1      <= 1'b1;
      r_bit2     <= '0;
      r_hit2     <= 1'b0;
      r_act2     <= 1'b0;
      r_hs2      <= 1'b1;
      r_vs2      <= 1'b1;
      r_pixel    <= 1'b0;
      r_disp     <= 1'b0;
      r_hs       <= 1'b1;
      r_vs       <= 1'b1;
    end else begin
      r_rd_char  <= r_mem[w_rd_addr];
      r_font_row <= w_glyph_row;
      r_bit1     <= w_glyph_bit;
      r_hit1     <= w_hit;
      r_act1     <= w_act;
      r_hs1      <= w_hs;
      r_vs1      <= w_vs;
      r_bit2     <= r_bit1;
      r_hit2     <= r_hit1;
      r_act2     <= r_act1;
      r_hs2      <= r_hs1;
      r_vs2      <= r_vs1;
      // font_bits arrives here, aligned with the stage-2 copies.
      r_pixel    <= r_act2 && (i_font_bits[BW'(CHAR_W - 1) - r_bit2] || r_hit2);
      r_disp     <= r_act2;
      r_hs       <= r_hs2;
      r_vs       <= r_vs2;
    end
  end

  assign o_wr_ready        = r_wr_ready;
  assign o_font_code       = r_rd_char;
  assign o_font_row        = r_font_row;
  assign o_vga_h_sync      = r_hs;
  assign o_vga_v_sync      = r_vs;
  assign o_in_display_area = r_disp;
  assign o_pixel_on        = r_pixel;
  assign o_cur_col         = r_cur_col;
  assign o_cur_row         = r_cur_row;
endmodule

// File: tb/tb_vga_text_console.sv
// Randomised bench for vga_text_console on a reduced raster, checked every cycle
// against a screen/cursor model built from the console's stated rules.
module tb_vga_text_console;
  localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_ACTIVE = 24, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int CHAR_W = 8, CHAR_H = 8, BLINK_FRAMES = 2;
  localparam int COLS = H_ACTIVE / CHAR_W, ROWS = V_ACTIVE / CHAR_H, CELLS = COLS * ROWS;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;

  logic                      i_clk, i_rst, i_wr_valid, i_clr;
  logic [7:0]                i_wr_char;
  logic                      o_wr_ready;
  logic [7:0]                o_font_code;
  logic [$clog2(CHAR_H)-1:0] o_font_row;
  logic [CHAR_W-1:0]         i_font_bits;
  logic                      o_vga_h_sync, o_vga_v_sync, o_in_display_area, o_pixel_on;
  logic [$clog2(COLS)-1:0]   o_cur_col;
  logic [$clog2(ROWS)-1:0]   o_cur_row;

  int checks = 0, failures = 0;
  logic [7:0] screen [CELLS];
  int mcol = 0, mrow = 0, clear_left = CELLS, quiet = 0, n_since = 0;
  bit chk_on = 1'b0;

  vga_text_console #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_valid(i_wr_valid), .i_wr_char(i_wr_char),
    .o_wr_ready(o_wr_ready), .i_clr(i_clr), .o_font_code(o_font_code),
    .o_font_row(o_font_row), .i_font_bits(i_font_bits), .o_vga_h_sync(o_vga_h_sync),
    .o_vga_v_sync(o_vga_v_sync), .o_in_display_area(o_in_display_area),
    .o_pixel_on(o_pixel_on), .o_cur_col(o_cur_col), .o_cur_row(o_cur_row)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [7:0] glyph(input logic [7:0] c, input int r);
    if (c == 8'h20) return 8'h00;
    if (c == 8'h41 && r == 0) return 8'hFF;
    return c ^ 8'(r * 29) ^ 8'h5A;
  endfunction

  // Stub font ROM with one cycle of read latency.
  always @(posedge i_clk) i_font_bits <= glyph(o_font_code, int'(o_font_row));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic blank_screen();
    for (int i = 0; i < CELLS; i++) screen[i] = 8'h20;
  endtask

  task automatic advance_row();
    mcol = 0;
    mrow = (mrow + 1) % ROWS;
  endtask

  task automatic apply_byte(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      screen[mrow * COLS + mcol] = c;
      if (mcol + 1 == COLS) advance_row();
      else mcol++;
    end else if (c == 8'h0A) begin
      advance_row();
    end else if (c == 8'h08) begin
      if (mcol > 0) mcol--;
      else if (mrow > 0) begin mcol = COLS - 1; mrow--; end
    end
  endtask

  task automatic model_step();
    if (i_rst) begin
      n_since = 0; clear_left = CELLS; mcol = 0; mrow = 0; quiet = 0;
      blank_screen();
    end else begin
      n_since++;
      if (i_clr) begin
        clear_left = CELLS; mcol = 0; mrow = 0; quiet = 0;
        blank_screen();
      end else if (clear_left > 0) begin
        clear_left--; quiet = 0;
      end else if (i_wr_valid) begin
        apply_byte(i_wr_char); quiet = 0;
      end else begin
        quiet++;
      end
    end
  endtask

  task automatic monitor();
    int m, x, y, col, row, gr, b;
    logic ehs, evs, eda, epx;
    logic [7:0] g;
    bit pix_chk;
    m = n_since - 3;
    if (m < 0) begin
      ehs = 1'b1; evs = 1'b1; eda = 1'b0; epx = 1'b0; pix_chk = 1'b1;
    end else begin
      x = m % HT;
      y = (m / HT) % VT;
      ehs = !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
      evs = !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
      eda = (x < H_ACTIVE) && (y < V_ACTIVE);
      pix_chk = (quiet >= 4);
      epx = 1'b0;
      if (eda) begin
        col = x / CHAR_W; row = y / CHAR_H; gr = y % CHAR_H; b = x % CHAR_W;
        g = glyph(screen[row * COLS + col], gr);
        epx = g[CHAR_W - 1 - b] ||
              (col == mcol && row == mrow && gr >= CHAR_H - 2 && ((m / FRAME) / BLINK_FRAMES) % 2 == 1);
      end
    end
    check_eq("hsync", o_vga_h_sync, ehs);
    check_eq("vsync", o_vga_v_sync, evs);
    check_eq("display_area", o_in_display_area, eda);
    if (pix_chk) check_eq("pixel", o_pixel_on, epx);
    check_eq("wr_ready", o_wr_ready, clear_left == 0);
    check_eq("cur_col", o_cur_col, mcol);
    check_eq("cur_row", o_cur_row, mrow);
  endtask

  initial forever begin
    @(posedge i_clk);
    model_step();
  end

  initial forever begin
    @(negedge i_clk);
    if (chk_on) monitor();
  end

  task automatic send_byte(input logic [7:0] c);
    int t = 0;
    while (!o_wr_ready && t < 4 * CELLS + 40) begin @(negedge i_clk); t++; end
    check_eq("ready_wait", o_wr_ready, 1'b1);
    i_wr_valid = 1'b1; i_wr_char = c;
    @(negedge i_clk);
    i_wr_valid = 1'b0;
  endtask

  task automatic pulse_clr(input bit with_byte, input logic [7:0] c);
    i_clr = 1'b1; i_wr_valid = with_byte; i_wr_char = c;
    @(negedge i_clk);
    i_clr = 1'b0; i_wr_valid = 1'b0;
  endtask

  task automatic count_clear(input string tag, input int exp_len);
    int cnt = 0;
    while (!o_wr_ready && cnt < 4 * CELLS + 40) begin @(negedge i_clk); cnt++; end
    check_eq(tag, cnt, exp_len);
  endtask

  task automatic idle_frame();
    repeat (FRAME + 8) @(negedge i_clk);
  endtask

  function automatic logic [7:0] rand_code();
    case ($urandom_range(0, 9))
      0: return 8'h0A;
      1: return 8'h08;
      2: return 8'($urandom_range(0, 31));
      3: return 8'($urandom_range(127, 255));
      default: return 8'($urandom_range(32, 126));
    endcase
  endfunction

  initial begin
    i_rst = 1'b1; i_clr = 1'b0; i_wr_valid = 1'b0; i_wr_char = 8'h00;
    repeat (2) @(posedge i_clk);
    chk_on = 1'b1;
    @(negedge i_clk);
    check_eq("rst_font_code", o_font_code, 8'h20);
    check_eq("rst_font_row", o_font_row, 0);
    check_eq("rst_pixel", o_pixel_on, 1'b0);
    i_rst = 1'b0;
    count_clear("clear_len_reset", CELLS);
    idle_frame();

    send_byte(8'h41);
    check_eq("A_col", o_cur_col, 1);
    check_eq("A_row", o_cur_row, 0);
    idle_frame();

    // Newline / backspace walk.
    pulse_clr(1'b0, 8'h00);
    for (int i = 0; i < COLS; i++) send_byte(8'($urandom_range(33, 126)));
    check_eq("full_line_col", o_cur_col, 0);
    check_eq("full_line_row", o_cur_row, 1);
    send_byte(8'h0A);
    check_eq("nl_col", o_cur_col, 0);
    check_eq("nl_row", o_cur_row, 2);
    send_byte(8'h08);
    check_eq("bs_wrap_col", o_cur_col, COLS - 1);
    check_eq("bs_wrap_row", o_cur_row, 1);
    send_byte(8'h08);
    check_eq("bs_col", o_cur_col, COLS - 2);
    check_eq("bs_row", o_cur_row, 1);
    idle_frame();

    // Last-cell wrap and backspace at home.
    pulse_clr(1'b0, 8'h00);
    for (int i = 0; i < CELLS - 1; i++) send_byte(8'($urandom_range(32, 126)));
    check_eq("last_cell_col", o_cur_col, COLS - 1);
    check_eq("last_cell_row", o_cur_row, ROWS - 1);
    send_byte(8'h41);
    check_eq("wrap_home_col", o_cur_col, 0);
    check_eq("wrap_home_row", o_cur_row, 0);
    send_byte(8'h08);
    check_eq("bs_home_col", o_cur_col, 0);
    check_eq("bs_home_row", o_cur_row, 0);
    idle_frame();

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 14; k++) begin
        send_byte(rand_code());
        repeat ($urandom_range(0, 3)) @(negedge i_clk);
      end
      idle_frame();
    end

    // clr with a simultaneous byte, then a restart partway through the clear.
    send_byte(8'h42);
    pulse_clr(1'b1, 8'h43);
    check_eq("clr_drop_col", o_cur_col, 0);
    check_eq("clr_drop_ready", o_wr_ready, 1'b0);
    count_clear("clear_len_clr", CELLS);
    pulse_clr(1'b0, 8'h00);
    repeat (9) @(negedge i_clk);
    pulse_clr(1'b0, 8'h00);
    count_clear("clear_len_restart", CELLS);
    send_byte(8'h41);
    idle_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
